// File: rtl/exe_driver_if.sv
// Command and result handshake bundle for exe_driver.
// The slave modport is the driver itself; the master modport is whoever feeds commands and consumes results.
interface exe_driver_if #(
    parameter int BITS = 8
);
    logic            i_cmd_valid;
    logic [BITS-1:0] i_cmd_a;
    logic [BITS-1:0] i_cmd_b;
    logic [1:0]      i_cmd_op;
    logic            o_cmd_ready;

    logic            o_res_valid;
    logic [BITS-1:0] o_res_data;
    logic [3:0]      o_res_status;
    logic [1:0]      o_res_op;
    logic            i_res_ready;

    modport slave (
        input  i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_op, i_res_ready,
        output o_cmd_ready, o_res_valid, o_res_data, o_res_status, o_res_op
    );

    modport master (
        output i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_op, i_res_ready,
        input  o_cmd_ready, o_res_valid, o_res_data, o_res_status, o_res_op
    );
endinterface

// File: rtl/exe_driver.sv
// Queues operand commands, drives them one at a time into a registered execution unit,
// and holds each returned result until the consumer takes it.
`ifndef ERROR_BIT
`define ERROR_BIT 3
`endif

module exe_driver #(
    parameter int BITS  = 8,
    parameter int DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    exe_driver_if.slave     bus,
    output logic [BITS-1:0] o_a,
    output logic [BITS-1:0] o_b,
    output logic [1:0]      o_op,
    input  logic [BITS-1:0] i_out,
    input  logic [3:0]      i_status,
    output logic            o_busy,
    output logic [7:0]      o_err_cnt,
    output logic [15:0]     o_done_cnt
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ERR_BIT = `ERROR_BIT;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [1:0]      op;
        logic [BITS-1:0] b;
        logic [BITS-1:0] a;
    } cmd_t;

    state_t           state_q;
    state_t           state_d;
    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             capture;
    logic             handoff;

    assign full            = (count == CNT_W'(DEPTH));
    assign empty           = (count == '0);
    assign bus.o_cmd_ready = !full;
    assign push            = bus.i_cmd_valid && !full;
    assign o_busy          = (state_q != IDLE);

    // NOTE: every output of this block gets a default first so no path leaves one unassigned,
    // which is what keeps synthesis from inferring latches.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
        handoff = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (bus.i_res_ready) begin
                    handoff = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values,
    // independent of the order the always_ff blocks are evaluated in.
    always_ff @(posedge i_clk) begin
        if (!i_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; an entry is only read after count says it was written,
    // so clearing it would cost a reset net per bit for nothing.
    always_ff @(posedge i_clk) begin
        if (i_rst && push) mem[wr_ptr] <= '{op: bus.i_cmd_op, b: bus.i_cmd_b, a: bus.i_cmd_a};
    end

    // Operands load only on a pop and otherwise keep the last issued command.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_a  <= '0;
            o_b  <= '0;
            o_op <= '0;
        end else if (pop) begin
            o_a  <= mem[rd_ptr].a;
            o_b  <= mem[rd_ptr].b;
            o_op <= mem[rd_ptr].op;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            bus.o_res_valid  <= 1'b0;
            bus.o_res_data   <= '0;
            bus.o_res_status <= '0;
            bus.o_res_op     <= '0;
        end else if (capture) begin
            bus.o_res_valid  <= 1'b1;
            bus.o_res_data   <= i_out;
            bus.o_res_status <= i_status;
            bus.o_res_op     <= o_op;
        end else if (handoff) begin
            bus.o_res_valid  <= 1'b0;
        end
    end

    // Error count saturates; done count wraps.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_err_cnt  <= '0;
            o_done_cnt <= '0;
        end else begin
            if (capture && i_status[ERR_BIT] && (o_err_cnt != 8'hFF)) o_err_cnt <= o_err_cnt + 8'd1;
            if (handoff) o_done_cnt <= o_done_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_exe_driver.sv
// Directed bench for exe_driver: a behavioural execution unit plus a result scoreboard
// filled when a command is accepted and drained when its result appears.
module tb_exe_driver;

    localparam int BITS  = 8;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] status;
        logic [1:0] op;
    } res_t;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [7:0]  o_a, o_b;
    logic [1:0]  o_op;
    logic [7:0]  i_out;
    logic [3:0]  i_status;
    logic        o_busy;
    logic [7:0]  o_err_cnt;
    logic [15:0] o_done_cnt;
    logic        err_mode;

    res_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   done_exp = 0;
    int   err_exp  = 0;

    exe_driver_if #(.BITS(BITS)) bus ();

    exe_driver #(.BITS(BITS), .DEPTH(DEPTH)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .bus        (bus),
        .o_a        (o_a),
        .o_b        (o_b),
        .o_op       (o_op),
        .i_out      (i_out),
        .i_status   (i_status),
        .o_busy     (o_busy),
        .o_err_cnt  (o_err_cnt),
        .o_done_cnt (o_done_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            2'b00:   return a - b;
            2'b01:   return a + b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    function automatic res_t exp_of(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        logic [7:0] r;
        r = alu(a, b, op);
        return '{data: r, status: {err_mode, 2'b00, (r == 8'h00)}, op: op};
    endfunction

    // Execution unit: status bit 3 flags an error, bit 0 a zero result.
    assign i_out    = alu(o_a, o_b, o_op);
    assign i_status = {err_mode, 2'b00, (i_out == 8'h00)};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        int k;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_a     = a;
        bus.i_cmd_b     = b;
        bus.i_cmd_op    = op;
        k = 0;
        while (!bus.o_cmd_ready && k < 50) begin
            step();
            k++;
        end
        check("push_ready", 32'(bus.o_cmd_ready), 32'd1);
        step();
        sb.push_back(exp_of(a, b, op));
        bus.i_cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int   k;
        res_t e;
        k = 0;
        while (!bus.o_res_valid && k < 40) begin
            step();
            k++;
        end
        check({tag, "_valid"}, 32'(bus.o_res_valid), 32'd1);
        if (sb.size() == 0) begin
            n_checks++;
            n_fails++;
            $error("FAIL %s_sb: observed result with empty scoreboard", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_data"},   32'(bus.o_res_data),   32'(e.data));
            check({tag, "_status"}, 32'(bus.o_res_status), 32'(e.status));
            check({tag, "_op"},     32'(bus.o_res_op),     32'(e.op));
        end
    endtask

    task automatic release_res();
        bus.i_res_ready = 1'b1;
        step();
        bus.i_res_ready = 1'b0;
        done_exp++;
        check("done_cnt",  32'(o_done_cnt),      32'(done_exp[15:0]));
        check("res_clear", 32'(bus.o_res_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t held;
        i_rst           = 1'b0;
        err_mode        = 1'b0;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_a     = '0;
        bus.i_cmd_b     = '0;
        bus.i_cmd_op    = '0;
        bus.i_res_ready = 1'b0;
        @(negedge clk);
        step();
        step();
        i_rst = 1'b1;

        // Reset state, ready in the first cycle after release
        check("rst_busy",  32'(o_busy),          32'd0);
        check("rst_valid", 32'(bus.o_res_valid), 32'd0);
        check("rst_ready", 32'(bus.o_cmd_ready), 32'd1);
        check("rst_err",   32'(o_err_cnt),       32'd0);
        check("rst_done",  32'(o_done_cnt),      32'd0);
        check("rst_a",     32'(o_a),             32'd0);
        check("rst_data",  32'(bus.o_res_data),  32'd0);

        // Single op with exact latency: push at E0, valid after E3
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_a     = 8'h05;
        bus.i_cmd_b     = 8'h03;
        bus.i_cmd_op    = 2'b00;
        step();
        bus.i_cmd_valid = 1'b0;
        sb.push_back(exp_of(8'h05, 8'h03, 2'b00));
        check("lat_e0_busy", 32'(o_busy), 32'd0);
        step();
        check("lat_e1_busy",  32'(o_busy),          32'd1);
        check("lat_e1_a",     32'(o_a),             32'h05);
        check("lat_e1_b",     32'(o_b),             32'h03);
        check("lat_e1_valid", 32'(bus.o_res_valid), 32'd0);
        step();
        check("lat_e2_valid", 32'(bus.o_res_valid), 32'd0);
        step();
        check("lat_e3_valid", 32'(bus.o_res_valid), 32'd1);
        check("single_data",  32'(bus.o_res_data),  32'h02);
        wait_valid("single");
        release_res();

        // Result-ready outside RESP is ignored
        bus.i_res_ready = 1'b1;
        step();
        step();
        bus.i_res_ready = 1'b0;
        check("idle_ready_done", 32'(o_done_cnt), 32'(done_exp[15:0]));
        check("idle_ready_busy", 32'(o_busy),     32'd0);

        // Fill: stall a result, fill the FIFO, fifth command waits for the first pop
        push_cmd(8'h10, 8'h01, 2'b01);
        wait_valid("fill_blk");
        for (int i = 0; i < 4; i++) push_cmd(8'h20 + 8'(i), 8'h0F, 2'(i));
        check("fill_full", 32'(bus.o_cmd_ready), 32'd0);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_a     = 8'h77;
        bus.i_cmd_b     = 8'h11;
        bus.i_cmd_op    = 2'b11;
        step();
        step();
        check("fill_blocked", 32'(bus.o_cmd_ready), 32'd0);
        release_res();
        check("fill_still_full", 32'(bus.o_cmd_ready), 32'd0);
        step();
        check("fill_reopen", 32'(bus.o_cmd_ready), 32'd1);
        step();
        sb.push_back(exp_of(8'h77, 8'h11, 2'b11));
        bus.i_cmd_valid = 1'b0;
        check("fill_refull", 32'(bus.o_cmd_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            wait_valid("fill_drain");
            release_res();
        end

        // Backpressure: result held stable for 10 cycles, one completion on release
        held = exp_of(8'hC8, 8'h37, 2'b00);
        push_cmd(8'hC8, 8'h37, 2'b00);
        wait_valid("bp");
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_valid",  32'(bus.o_res_valid),  32'd1);
            check("bp_data",   32'(bus.o_res_data),   32'(held.data));
            check("bp_status", 32'(bus.o_res_status), 32'(held.status));
            check("bp_op",     32'(bus.o_res_op),     32'(held.op));
            check("bp_done",   32'(o_done_cnt),       32'(done_exp[15:0]));
        end
        release_res();

        // Simultaneous push and pop with two queued entries
        push_cmd(8'h01, 8'h02, 2'b01);
        wait_valid("sim_blk");
        push_cmd(8'hA1, 8'h0A, 2'b00);
        push_cmd(8'hA2, 8'h0B, 2'b10);
        check("sim_two", 32'(bus.o_cmd_ready), 32'd1);
        release_res();
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_a     = 8'hA3;
        bus.i_cmd_b     = 8'h0C;
        bus.i_cmd_op    = 2'b11;
        step();
        sb.push_back(exp_of(8'hA3, 8'h0C, 2'b11));
        bus.i_cmd_valid = 1'b0;
        check("sim_pop_busy", 32'(o_busy),          32'd1);
        check("sim_ready2",   32'(bus.o_cmd_ready), 32'd1);
        push_cmd(8'hA4, 8'h0D, 2'b01);
        check("sim_ready3", 32'(bus.o_cmd_ready), 32'd1);
        push_cmd(8'hA5, 8'h0E, 2'b00);
        check("sim_full4", 32'(bus.o_cmd_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            wait_valid("sim_drain");
            release_res();
        end

        // Error counter saturates at 0xFF
        err_mode = 1'b1;
        for (int i = 0; i < 260; i++) begin
            push_cmd(8'(i), 8'h01, 2'(i));
            wait_valid("err");
            if (err_exp < 255) err_exp++;
            check("err_cnt", 32'(o_err_cnt), 32'(err_exp));
            release_res();
        end
        check("err_sat", 32'(o_err_cnt), 32'hFF);
        err_mode = 1'b0;

        // Reset while WAIT with three queued commands
        push_cmd(8'h40, 8'h04, 2'b10);
        wait_valid("rw_blk");
        for (int i = 0; i < 4; i++) push_cmd(8'h50 + 8'(i), 8'h05, 2'b01);
        release_res();
        step();
        step();
        check("rw_busy_pre",  32'(o_busy),          32'd1);
        check("rw_valid_pre", 32'(bus.o_res_valid), 32'd0);
        i_rst = 1'b0;
        step();
        i_rst = 1'b1;
        sb.delete();
        done_exp = 0;
        err_exp  = 0;
        check("rw_busy",  32'(o_busy),          32'd0);
        check("rw_valid", 32'(bus.o_res_valid), 32'd0);
        check("rw_ready", 32'(bus.o_cmd_ready), 32'd1);
        check("rw_err",   32'(o_err_cnt),       32'd0);
        check("rw_done",  32'(o_done_cnt),      32'd0);
        check("rw_data",  32'(bus.o_res_data),  32'd0);
        check("rw_a",     32'(o_a),             32'd0);
        bus.i_res_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("rw_no_stale", 32'(bus.o_res_valid), 32'd0);
            check("rw_idle",     32'(o_busy),          32'd0);
        end
        bus.i_res_ready = 1'b0;
        push_cmd(8'h09, 8'h04, 2'b00);
        wait_valid("post_rst");
        release_res();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/exe_driver.md
EXE_DRIVER -- requirements
Module: exe_driver

Interface
REQ-001 Parameter BITS, default 8: operand and result width.
REQ-002 Parameter DEPTH, default 4: command FIFO entries; power of 2, at least 2.
REQ-003 Clock and reset: i_clk, input, 1 bit. Reset is i_rst, synchronous, active-low; clock is i_clk.
REQ-004 i_rst  input  1  synchronous active-low reset.
REQ-005 Command port inputs:
- i_cmd_valid  1  command offered.
- i_cmd_a  BITS  operand A.
- i_cmd_b  BITS  operand B.
- i_cmd_op  2  opcode.
REQ-006 o_cmd_ready  output  1  FIFO can accept.
REQ-007 Execution-unit drive outputs:
- o_a  BITS  operand A to the execution unit.
- o_b  BITS  operand B to the execution unit.
- o_op  2  opcode to the execution unit.
REQ-008 Execution-unit return inputs:
- i_out  BITS  execution-unit result.
- i_status  4  execution-unit status.
REQ-009 Result port outputs:
- o_res_valid  1  result held.
- o_res_data  BITS  captured i_out.
- o_res_status  4  captured i_status.
- o_res_op  2  opcode of the result.
REQ-010 i_res_ready  input  1  consumer accepts result.
REQ-011 Status outputs:
- o_busy  1  high when state is not IDLE.
- o_err_cnt  8  results with error status.
- o_done_cnt  16  results handed off.

Function
REQ-012 Push: command enters the FIFO tail at a rising edge when i_cmd_valid && o_cmd_ready.
REQ-013 o_cmd_ready SHALL be !full, decoded from the registered count, so there is no combinational path from i_cmd_valid.
REQ-014 FIFO order is strict FIFO; pointers wrap modulo DEPTH; count range is 0..DEPTH.
REQ-015 Push and pop at the same edge SHALL leave the count unchanged; the pushed entry is preserved.
REQ-016 FSM states are IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE:
- FIFO non-empty: at the edge, pop the head into o_a/o_b/o_op (registered), go to ISSUE.
- FIFO empty: stay in IDLE.
REQ-018 ISSUE: o_a/o_b/o_op SHALL be held stable; unconditionally go to WAIT (the execution unit registers the operands at this edge).
REQ-019 WAIT, at the edge:
- register i_out into o_res_data, i_status into o_res_status, o_op into o_res_op;
- set o_res_valid = 1;
- go to RESP.
REQ-020 RESP: hold all result outputs stable while o_res_valid && !i_res_ready.
REQ-021 RESP handshake: on an edge with i_res_ready = 1, clear o_res_valid, increment o_done_cnt (16-bit, wraps 0xFFFF->0x0000), go to IDLE.
REQ-022 Operands o_a/o_b/o_op SHALL retain the last issued command outside IDLE->ISSUE pops.
REQ-023 Latency: a command pushed into an empty, idle block at edge E0 SHALL produce o_res_valid = 1 after edge E3.
REQ-024 Throughput: at most one command per 4 cycles.
REQ-025 o_err_cnt SHALL increment in the WAIT capture when i_status[`ERROR_BIT] = 1 (macros.hv); it saturates at 0xFF.
REQ-026 o_busy = (state != IDLE), decoded from registered state.
REQ-027 Commands may be pushed in any state, including while a result stalls in RESP.
REQ-028 i_res_ready asserted outside RESP SHALL have no effect.

Reset
REQ-029 When i_rst = 0 at an edge:
- state = IDLE, FIFO emptied (pointers and count = 0);
- o_a, o_b, o_op, o_res_data, o_res_status, o_res_op = 0;
- o_res_valid = 0, o_err_cnt = 0, o_done_cnt = 0.
REQ-030 Reset mid-operation (ISSUE/WAIT/RESP) SHALL discard the in-flight command, the pending result and all queued commands, without incrementing any counter.
REQ-031 After reset release, o_cmd_ready SHALL be 1 in the first cycle.

Verification
REQ-032 Single op: push a=0x05 b=0x03 op=00 at E0, model returns i_out=0x02, i_status=0 during WAIT -> o_res_valid high after E3, o_res_data=0x02, o_res_op=00, o_done_cnt=1 after handshake.
REQ-033 Fill: with i_res_ready = 0, push 5 commands back-to-back ->
- 4 commands accepted (o_cmd_ready falls after the 4th push);
- the first pop reopens one slot;
- results emerge in push order as i_res_ready is toggled.
REQ-034 Backpressure: hold i_res_ready = 0 for 10 cycles in RESP -> o_res_data/status/op unchanged; o_done_cnt increments exactly once on release.
REQ-035 Errors: 260 ops whose model status has ERROR_BIT=1 -> o_err_cnt = 0xFF, no wrap.
REQ-036 Simultaneous: with FIFO count 2, push and pop at the same edge -> count stays 2; order preserved.
REQ-037 Reset in WAIT with 3 queued commands -> next cycle:
- o_busy = 0, o_res_valid = 0, o_cmd_ready = 1;
- counters 0;
- no stale result ever emitted.
